// File: rtl/spike_motor_decoder.sv
// Rate decoder for the two-neuron SNN output layer: counts L/R spikes over a
// window of enabled cycles and presents a motor command through a one-deep valid/ready register.
module spike_motor_decoder #(
   parameter int unsigned WIN_LEN    = 256,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned THRESH_MIN = 4,
   parameter int unsigned HYST       = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike_l,
   input  logic             spike_r,
   input  logic             cmd_ready,
   output logic             cmd_valid,
   output logic [1:0]       cmd,
   output logic [CNT_W-1:0] rate_l,
   output logic [CNT_W-1:0] rate_r,
   output logic             overrun
);

   localparam int unsigned WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam int unsigned CMP_W = CNT_W + 2;

   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CMP_W-1:0] THRESH_C = CMP_W'(THRESH_MIN);
   localparam logic [CMP_W-1:0] HYST_C   = CMP_W'(HYST);

   localparam logic [1:0] CMD_STOP    = 2'b00;
   localparam logic [1:0] CMD_LEFT    = 2'b01;
   localparam logic [1:0] CMD_RIGHT   = 2'b10;
   localparam logic [1:0] CMD_FORWARD = 2'b11;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] cnt_l;
   logic [CNT_W-1:0] cnt_r;

   logic             win_end_c;
   logic [CNT_W-1:0] fin_l_c;
   logic [CNT_W-1:0] fin_r_c;
   logic [CMP_W-1:0] ext_l_c;
   logic [CMP_W-1:0] ext_r_c;
   logic [1:0]       dec_c;

   // Counts including this cycle's spikes, and the decision they produce
   always_comb begin
      win_end_c = en && (win_cnt == WIN_LAST);
      fin_l_c   = (spike_l && (cnt_l != CNT_MAX)) ? cnt_l + CNT_W'(1) : cnt_l;
      fin_r_c   = (spike_r && (cnt_r != CNT_MAX)) ? cnt_r + CNT_W'(1) : cnt_r;
      ext_l_c   = CMP_W'(fin_l_c);
      ext_r_c   = CMP_W'(fin_r_c);
      dec_c     = CMD_FORWARD;
      if ((ext_l_c < THRESH_C) && (ext_r_c < THRESH_C))
         dec_c = CMD_STOP;
      else if (ext_l_c >= ext_r_c + HYST_C)
         dec_c = CMD_LEFT;
      else if (ext_r_c >= ext_l_c + HYST_C)
         dec_c = CMD_RIGHT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         win_cnt   <= '0;
         cnt_l     <= '0;
         cnt_r     <= '0;
         cmd_valid <= 1'b0;
         cmd       <= CMD_STOP;
         rate_l    <= '0;
         rate_r    <= '0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;

         if (en) begin
            if (win_end_c) begin
               win_cnt <= '0;
               cnt_l   <= '0;
               cnt_r   <= '0;
            end else begin
               win_cnt <= win_cnt + WIN_W'(1);
               cnt_l   <= fin_l_c;
               cnt_r   <= fin_r_c;
            end
         end

         // A window end always loads; in FULL it overwrites unless the old command is taken now
         if (win_end_c) begin
            cmd    <= dec_c;
            rate_l <= fin_l_c;
            rate_r <= fin_r_c;
         end

         if (state == EMPTY) begin
            if (win_end_c) begin
               state     <= FULL;
               cmd_valid <= 1'b1;
            end
         end else begin
            if (win_end_c) begin
               overrun <= !cmd_ready;
            end else if (cmd_ready) begin
               state     <= EMPTY;
               cmd_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_spike_motor_decoder.sv
// Scoreboard bench for spike_motor_decoder: a window-level reference model predicts
// commands for two configurations driven by the same random/directed stimulus.
module tb_spike_motor_decoder;

   localparam int unsigned WL0 = 16;
   localparam int unsigned WL1 = 32;

   logic       clk = 1'b0;
   logic       rst, en, spike_l, spike_r, cmd_ready;
   logic       v0, o0, v1, o1;
   logic [1:0] c0, c1;
   logic [7:0] rl0, rr0;
   logic [3:0] rl1, rr1;

   spike_motor_decoder #(.WIN_LEN(WL0), .CNT_W(8), .THRESH_MIN(4), .HYST(2)) dut (
      .clk(clk), .rst(rst), .en(en), .spike_l(spike_l), .spike_r(spike_r),
      .cmd_ready(cmd_ready), .cmd_valid(v0), .cmd(c0), .rate_l(rl0), .rate_r(rr0),
      .overrun(o0));

   spike_motor_decoder #(.WIN_LEN(WL1), .CNT_W(4), .THRESH_MIN(4), .HYST(2)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .spike_l(spike_l), .spike_r(spike_r),
      .cmd_ready(cmd_ready), .cmd_valid(v1), .cmd(c1), .rate_l(rl1), .rate_r(rr1),
      .overrun(o1));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] cmd;
      logic [7:0] rl;
      logic [7:0] rr;
   } exp_t;

   exp_t q[2][$];
   int   n[2], sl[2], sr[2];
   bit   ovr[2];
   bit   started = 1'b0;
   int   checks = 0;
   int   errors = 0;

   function automatic logic [1:0] decide(input int l, input int r);
      if (l < 4 && r < 4) return 2'b00;
      if (l >= r + 2) return 2'b01;
      if (r >= l + 2) return 2'b10;
      return 2'b11;
   endfunction

   function automatic int sat(input int x, input int mx);
      return (x > mx) ? mx : x;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: a window closes after WIN_LEN enabled cycles; the output slot holds one command
   always @(posedge clk) begin
      started = 1'b1;
      for (int i = 0; i < 2; i++) begin
         int   wl, mx, lf, rf;
         exp_t e;
         wl = (i == 0) ? WL0 : WL1;
         mx = (i == 0) ? 255 : 15;
         if (rst) begin
            n[i] = 0; sl[i] = 0; sr[i] = 0; ovr[i] = 1'b0;
            q[i].delete();
         end else begin
            ovr[i] = 1'b0;
            if (q[i].size() > 0 && cmd_ready) void'(q[i].pop_front());
            if (en) begin
               n[i]++;
               sl[i] += int'(spike_l);
               sr[i] += int'(spike_r);
               if (n[i] == wl) begin
                  lf = sat(sl[i], mx);
                  rf = sat(sr[i], mx);
                  e.cmd = decide(lf, rf);
                  e.rl  = 8'(lf);
                  e.rr  = 8'(rf);
                  if (q[i].size() > 0) begin
                     void'(q[i].pop_front());
                     ovr[i] = 1'b1;
                  end
                  q[i].push_back(e);
                  n[i] = 0; sl[i] = 0; sr[i] = 0;
               end
            end
         end
      end
   end

   // Monitor: compare presented outputs against the scoreboard head every cycle
   always @(negedge clk) begin
      if (started) begin
         chk("valid0", 32'(v0), 32'(q[0].size() > 0));
         chk("overrun0", 32'(o0), 32'(ovr[0]));
         if (q[0].size() > 0) begin
            chk("cmd0", 32'(c0), 32'(q[0][0].cmd));
            chk("rate_l0", 32'(rl0), 32'(q[0][0].rl));
            chk("rate_r0", 32'(rr0), 32'(q[0][0].rr));
         end
         chk("valid1", 32'(v1), 32'(q[1].size() > 0));
         chk("overrun1", 32'(o1), 32'(ovr[1]));
         if (q[1].size() > 0) begin
            chk("cmd1", 32'(c1), 32'(q[1][0].cmd));
            chk("rate_l1", 32'(rl1), 32'(q[1][0].rl));
            chk("rate_r1", 32'(rr1), 32'(q[1][0].rr));
         end
      end
   end

   task automatic cyc(input bit e, input bit l, input bit r, input bit rdy);
      en = e; spike_l = l; spike_r = r; cmd_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(v0), 32'd0);
      chk({tag, "_cmd"}, 32'(c0), 32'd0);
      chk({tag, "_rate_l"}, 32'(rl0), 32'd0);
      chk({tag, "_rate_r"}, 32'(rr0), 32'd0);
      chk({tag, "_overrun"}, 32'(o0), 32'd0);
      chk({tag, "_valid_sat"}, 32'(v1), 32'd0);
   endtask

   int pl[6] = '{16, 4, 8, 9, 3, 5};
   int pr[6] = '{4, 16, 8, 8, 3, 3};

   initial begin
      rst = 1'b1;
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk_zero("reset");
      rst = 1'b0;

      // Quiet window with no consumer: STOP appears after exactly WL0 enabled cycles
      for (int k = 0; k < 16; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("first_cmd_valid", 32'(v0), 32'd1);
      chk("first_cmd", 32'(c0), 32'd0);

      // Directed rate pairs; consumer rarely ready so some overwrites occur
      for (int p = 0; p < 6; p++)
         for (int k = 0; k < 16; k++)
            cyc(1'b1, k < pl[p], k < pr[p], $urandom_range(0, 3) == 0);

      // Two windows unconsumed (overrun), then ready exactly on the third window end
      for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, k % 4 == 0, 1'b0);
      for (int k = 0; k < 16; k++) cyc(1'b1, k % 4 == 0, 1'b1, 1'b0);
      for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 1'b1, k == 15);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);

      // Enable gap mid-window with spike_l held high
      for (int k = 0; k < 21; k++)
         cyc(!(k >= 6 && k < 11), 1'b1, 1'b0, 1'b1);

      // Long constant spike_l run saturates the 4-bit configuration
      for (int k = 0; k < 64; k++) cyc(1'b1, 1'b1, 1'b0, $urandom_range(0, 1) == 0);

      // Randomised windows with per-window rate targets, random enable and handshake
      for (int w = 0; w < 40; w++) begin
         int tl, tr;
         tl = $urandom_range(0, 16);
         tr = $urandom_range(0, 16);
         for (int k = 0; k < 16; k++)
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 15) < tl,
                $urandom_range(0, 15) < tr, $urandom_range(0, 3) == 0);
      end

      // Reset mid-window while a command is pending
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk("pre_reset_valid", 32'(v0), 32'd1);
      rst = 1'b1;
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk_zero("midreset");
      rst = 1'b0;
      for (int k = 0; k < 15; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("post_reset_not_yet", 32'(v0), 32'd0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("post_reset_valid", 32'(v0), 32'd1);

      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
